mem_access_stage: RTL and testbench

//  Parametrised MEM pipeline stage for the LoongArch core: sits between EX and WB.

---
 rtl/mycpu_pkg.sv | 20 ++
 rtl/load_extract.sv | 40 ++++
 rtl/mem_access_stage.sv | 134 +++++++++++++
 tb/tb_mem_access_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared definitions for the LoongArch pipeline: load-op encodings, default width
// and the MEM-stage state type.
package mycpu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] MEM_OP_W  = 3'b000;
    localparam logic [2:0] MEM_OP_B  = 3'b001;
    localparam logic [2:0] MEM_OP_H  = 3'b010;
    localparam logic [2:0] MEM_OP_BU = 3'b011;
    localparam logic [2:0] MEM_OP_HU = 3'b100;
    localparam logic [2:0] MEM_OP_D  = 3'b101;

    typedef enum logic [1:0] {
        MS_EMPTY     = 2'd0,
        MS_WAIT_DATA = 2'd1,
        MS_READY     = 2'd2
    } ms_state_e;

endpackage

// File: rtl/load_extract.sv
// Picks the addressed byte/half/word out of a read response and extends it to XLEN.
// Purely combinational so it can be shared with a future LSU.
module load_extract
    import mycpu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int LANE_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]   rdata,
    input  logic [LANE_W-1:0] lane,
    input  logic [2:0]        mem_op,
    output logic [XLEN-1:0]   result
);

    logic [LANE_W-1:0] lane_h;
    logic [LANE_W-1:0] lane_w;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [31:0]       word_val;

    // Low address bits below the access size are ignored; misalignment is trapped in EX.
    assign lane_h   = lane & ~LANE_W'(1);
    assign lane_w   = lane & ~LANE_W'(3);
    assign byte_val = rdata[{lane,   3'b000} +: 8];
    assign half_val = rdata[{lane_h, 3'b000} +: 16];
    assign word_val = rdata[{lane_w, 3'b000} +: 32];

    always_comb begin
        result = rdata;
        case (mem_op)
            MEM_OP_B:  result = XLEN'($signed(byte_val));
            MEM_OP_BU: result = XLEN'(byte_val);
            MEM_OP_H:  result = XLEN'($signed(half_val));
            MEM_OP_HU: result = XLEN'(half_val);
            MEM_OP_W:  result = XLEN'($signed(word_val));
            default:   result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage between EX and WB: waits for split-transaction load responses, extends
// sub-word loads, forwards results to ID and drops responses of flushed loads.
module mem_access_stage
    import mycpu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int MAX_OUTS = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            ws_allowin,
    output logic            ms_allowin,
    input  logic            es_to_ms_valid,
    input  logic            es_res_from_mem,
    input  logic [2:0]      es_mem_op,
    input  logic            es_gr_we,
    input  logic [4:0]      es_dest,
    input  logic [XLEN-1:0] es_alu_result,
    input  logic [31:0]     es_pc,
    input  logic            data_sram_data_ok,
    input  logic [XLEN-1:0] data_sram_rdata,
    output logic            ms_to_ws_valid,
    output logic            ms_gr_we,
    output logic [4:0]      ms_dest,
    output logic [XLEN-1:0] ms_final_result,
    output logic [31:0]     ms_pc,
    output logic            ms_fwd_valid,
    output logic [4:0]      ms_fwd_dest,
    output logic            ms_fwd_data_ok,
    output logic [XLEN-1:0] ms_fwd_data,
    output logic            ms_load_busy
);

    localparam int LANE_W = $clog2(XLEN / 8);
    localparam int CNT_W  = $clog2(MAX_OUTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTS);

    ms_state_e         state_reg, state_next;
    logic [CNT_W-1:0]  cancel_cnt_reg, cancel_cnt_next;
    logic              gr_we_reg;
    logic [4:0]        dest_reg;
    logic [31:0]       pc_reg;
    logic [2:0]        mem_op_reg;
    logic [XLEN-1:0]   result_reg;
    logic [XLEN-1:0]   load_data;
    logic              accept, resp_take, cnt_inc, cnt_dec;

    assign ms_allowin = (state_reg == MS_EMPTY) || ((state_reg == MS_READY) && ws_allowin);
    assign accept     = es_to_ms_valid && ms_allowin && !flush;
    // Any response arriving while stale loads remain belongs to one of them.
    assign cnt_dec    = data_sram_data_ok && (cancel_cnt_reg != '0);
    assign resp_take  = data_sram_data_ok && (cancel_cnt_reg == '0) &&
                        (state_reg == MS_WAIT_DATA) && !flush;
    assign cnt_inc    = flush && (state_reg == MS_WAIT_DATA) &&
                        !(data_sram_data_ok && (cancel_cnt_reg == '0));

    // result_reg holds the load address until the response overwrites it.
    load_extract #(.XLEN(XLEN)) u_load_extract (
        .rdata  (data_sram_rdata),
        .lane   (result_reg[LANE_W-1:0]),
        .mem_op (mem_op_reg),
        .result (load_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= MS_EMPTY;
            cancel_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cancel_cnt_reg <= cancel_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cancel_cnt_next = cancel_cnt_reg;
        if (cnt_inc && !cnt_dec && (cancel_cnt_reg != CNT_MAX))
            cancel_cnt_next = cancel_cnt_reg + CNT_W'(1);
        else if (cnt_dec && !cnt_inc)
            cancel_cnt_next = cancel_cnt_reg - CNT_W'(1);

        if (flush) begin
            state_next = MS_EMPTY;
        end else begin
            case (state_reg)
                MS_EMPTY:
                    if (accept) state_next = es_res_from_mem ? MS_WAIT_DATA : MS_READY;
                MS_WAIT_DATA:
                    if (resp_take) state_next = MS_READY;
                MS_READY:
                    if (ws_allowin) begin
                        if (accept) state_next = es_res_from_mem ? MS_WAIT_DATA : MS_READY;
                        else        state_next = MS_EMPTY;
                    end
                default: state_next = MS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gr_we_reg  <= 1'b0;
            dest_reg   <= '0;
            pc_reg     <= '0;
            mem_op_reg <= '0;
            result_reg <= '0;
        end else if (accept) begin
            gr_we_reg  <= es_gr_we;
            dest_reg   <= es_dest;
            pc_reg     <= es_pc;
            mem_op_reg <= es_mem_op;
            result_reg <= es_alu_result;
        end else if (resp_take) begin
            result_reg <= load_data;
        end
    end

    assign ms_to_ws_valid  = (state_reg == MS_READY) && !flush;
    assign ms_gr_we        = gr_we_reg;
    assign ms_dest         = dest_reg;
    assign ms_pc           = pc_reg;
    assign ms_final_result = result_reg;
    assign ms_fwd_valid    = (state_reg != MS_EMPTY) && gr_we_reg && (dest_reg != 5'd0);
    assign ms_fwd_dest     = dest_reg;
    assign ms_fwd_data_ok  = (state_reg == MS_READY);
    assign ms_fwd_data     = result_reg;
    assign ms_load_busy    = (state_reg == MS_WAIT_DATA) || (cancel_cnt_reg != '0);

    cancel_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(cnt_inc && !cnt_dec && (cancel_cnt_reg == CNT_MAX)));

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized checks of mem_access_stage against a response-queue model.
module tb_mem_access_stage;
    import mycpu_pkg::*;

    localparam int XLEN     = 32;
    localparam int MAX_OUTS = 2;

    logic            clk = 1'b0;
    logic            resetn, flush, ws_allowin, ms_allowin;
    logic            es_to_ms_valid, es_res_from_mem, es_gr_we;
    logic [2:0]      es_mem_op;
    logic [4:0]      es_dest;
    logic [XLEN-1:0] es_alu_result;
    logic [31:0]     es_pc;
    logic            data_sram_data_ok;
    logic [XLEN-1:0] data_sram_rdata;
    logic            ms_to_ws_valid, ms_gr_we, ms_fwd_valid, ms_fwd_data_ok, ms_load_busy;
    logic [4:0]      ms_dest, ms_fwd_dest;
    logic [XLEN-1:0] ms_final_result, ms_fwd_data;
    logic [31:0]     ms_pc;

    always #5 clk = ~clk;

    mem_access_stage #(.XLEN(XLEN), .MAX_OUTS(MAX_OUTS)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .ws_allowin(ws_allowin),
        .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
        .es_res_from_mem(es_res_from_mem), .es_mem_op(es_mem_op), .es_gr_we(es_gr_we),
        .es_dest(es_dest), .es_alu_result(es_alu_result), .es_pc(es_pc),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
        .ms_final_result(ms_final_result), .ms_pc(ms_pc), .ms_fwd_valid(ms_fwd_valid),
        .ms_fwd_dest(ms_fwd_dest), .ms_fwd_data_ok(ms_fwd_data_ok),
        .ms_fwd_data(ms_fwd_data), .ms_load_busy(ms_load_busy)
    );

    // Every issued load owns one queue entry; a flush turns all pending entries stale.
    typedef struct {
        logic [31:0] rdata;
        bit          live;
    } resp_t;

    resp_t       mem_q[$];
    bit          m_busy, m_has_data, m_we;
    logic [31:0] m_pc, m_res, m_addr;
    logic [4:0]  m_dest;
    logic [2:0]  m_op;
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic logic [31:0] ref_load(logic [2:0] op, logic [31:0] addr, logic [31:0] rd);
        logic [31:0] v;
        int          off;
        v = rd;
        case (op)
            MEM_OP_B, MEM_OP_BU: begin
                off = int'(addr % 4);
                v = (rd >> (8 * off)) & 32'hFF;
                if (op == MEM_OP_B && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            MEM_OP_H, MEM_OP_HU: begin
                off = int'(addr % 4) / 2 * 2;
                v = (rd >> (8 * off)) & 32'hFFFF;
                if (op == MEM_OP_H && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit ev, input bit ld, input logic [2:0] op, input logic [31:0] addr,
                        input logic [4:0] dest, input bit we, input logic [31:0] pc,
                        input bit wsal, input bit fl, input bit dok, input logic [31:0] rd);
        bit    exp_allowin, exp_valid, handoff, acc;
        resp_t r;
        if (dok && mem_q.size() == 0) dok = 1'b0;
        es_to_ms_valid    = ev;
        es_res_from_mem   = ld;
        es_mem_op         = op;
        es_alu_result     = addr;
        es_dest           = dest;
        es_gr_we          = we;
        es_pc             = pc;
        ws_allowin        = wsal;
        flush             = fl;
        data_sram_data_ok = dok;
        data_sram_rdata   = dok ? mem_q[0].rdata : $urandom;
        #2;
        exp_allowin = !m_busy || (m_has_data && wsal);
        exp_valid   = m_busy && m_has_data && !fl;
        check("allowin", 64'(ms_allowin), 64'(exp_allowin));
        check("to_ws_valid", 64'(ms_to_ws_valid), 64'(exp_valid));
        check("load_busy", 64'(ms_load_busy), 64'(mem_q.size() != 0));
        check("fwd_valid", 64'(ms_fwd_valid), 64'(m_busy && m_we && m_dest != 5'd0));
        check("fwd_data_ok", 64'(ms_fwd_data_ok), 64'(m_busy && m_has_data));
        if (exp_valid) begin
            check("result", 64'(ms_final_result), 64'(m_res));
            check("dest", 64'(ms_dest), 64'(m_dest));
            check("pc", 64'(ms_pc), 64'(m_pc));
            check("gr_we", 64'(ms_gr_we), 64'(m_we));
        end
        if (m_busy && m_we && m_dest != 5'd0) check("fwd_dest", 64'(ms_fwd_dest), 64'(m_dest));
        if (m_busy && m_has_data) check("fwd_data", 64'(ms_fwd_data), 64'(m_res));

        handoff = exp_valid && wsal;
        acc     = ev && exp_allowin && !fl;
        if (dok) begin
            r = mem_q.pop_front();
            if (r.live && !fl) begin
                m_res      = ref_load(m_op, m_addr, r.rdata);
                m_has_data = 1'b1;
            end
        end
        if (fl) begin
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
            m_busy = 1'b0;
        end else begin
            if (handoff) m_busy = 1'b0;
            if (acc) begin
                m_busy     = 1'b1;
                m_has_data = !ld;
                m_pc       = pc;
                m_dest     = dest;
                m_we       = we;
                m_op       = op;
                m_addr     = addr;
                m_res      = addr;
                if (ld) mem_q.push_back('{rdata: rd, live: 1'b1});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit wsal, input bit fl, input bit dok);
        step(1'b0, 1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0, wsal, fl, dok, 32'h0);
    endtask

    initial begin
        bit          ev, ld, wsal, fl, dok;
        logic [2:0]  op;

        resetn = 1'b0; flush = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0;
        es_res_from_mem = 1'b0; es_mem_op = '0; es_gr_we = 1'b0; es_dest = '0;
        es_alu_result = '0; es_pc = '0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        m_busy = 0; m_has_data = 0; m_we = 0; m_pc = 0; m_res = 0; m_addr = 0; m_dest = 0; m_op = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_allowin", 64'(ms_allowin), 64'd1);
        check("rst_valid", 64'(ms_to_ws_valid), 64'd0);
        check("rst_result", 64'(ms_final_result), 64'd0);
        check("rst_pc", 64'(ms_pc), 64'd0);
        check("rst_dest", 64'(ms_dest), 64'd0);
        check("rst_fwd_valid", 64'(ms_fwd_valid), 64'd0);
        check("rst_fwd_data_ok", 64'(ms_fwd_data_ok), 64'd0);
        check("rst_load_busy", 64'(ms_load_busy), 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // ALU op appears to WB one cycle after acceptance.
        step(1, 0, MEM_OP_W, 32'h1234, 5'd5, 1, 32'h1c00_0000, 1, 0, 0, 0);
        check("alu_valid", 64'(ms_to_ws_valid), 64'd1);
        check("alu_result", 64'(ms_final_result), 64'h1234);
        idle(1, 0, 0);

        // Sub-word extraction.
        step(1, 1, MEM_OP_B, 32'h1c01_0003, 5'd6, 1, 32'h1c00_0004, 1, 0, 0, 32'h80FF_0000);
        idle(1, 0, 1);
        check("ldb_result", 64'(ms_final_result), 64'hFFFF_FF80);
        idle(1, 0, 0);
        step(1, 1, MEM_OP_HU, 32'h1c01_0002, 5'd7, 1, 32'h1c00_0008, 1, 0, 0, 32'h80FF_0000);
        idle(1, 0, 1);
        check("ldhu_result", 64'(ms_final_result), 64'h0000_80FF);
        idle(1, 0, 0);

        // Response three cycles late: bypass not usable and MEM stalls meanwhile.
        step(1, 1, MEM_OP_W, 32'h40, 5'd8, 1, 32'h1c00_000c, 1, 0, 0, 32'h1122_3344);
        for (int i = 0; i < 3; i++) begin
            check("late_fwd_ok", 64'(ms_fwd_data_ok), 64'd0);
            check("late_allowin", 64'(ms_allowin), 64'd0);
            idle(1, 0, 0);
        end
        idle(1, 0, 1);
        check("late_valid", 64'(ms_to_ws_valid), 64'd1);
        check("late_result", 64'(ms_final_result), 64'h1122_3344);
        idle(1, 0, 0);

        // Response held while WB back-pressures.
        step(1, 1, MEM_OP_H, 32'h2, 5'd9, 1, 32'h1c00_0010, 1, 0, 0, 32'h8001_0000);
        idle(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", 64'(ms_to_ws_valid), 64'd1);
            check("hold_result", 64'(ms_final_result), 64'hFFFF_8001);
            idle(0, 0, 0);
        end
        idle(1, 0, 0);
        check("hold_drained", 64'(ms_to_ws_valid), 64'd0);

        // Flush while waiting: the stale response is dropped, the next load gets its own.
        step(1, 1, MEM_OP_W, 32'h80, 5'd10, 1, 32'h1c00_0014, 1, 0, 0, 32'hDEAD_BEEF);
        idle(1, 1, 0);
        check("flush_busy", 64'(ms_load_busy), 64'd1);
        step(1, 1, MEM_OP_W, 32'h100, 5'd11, 1, 32'h1c00_0018, 1, 0, 0, 32'hCAFE_BABE);
        idle(1, 0, 1);
        check("drop_not_ready", 64'(ms_fwd_data_ok), 64'd0);
        idle(1, 0, 1);
        check("flush_result", 64'(ms_final_result), 64'hCAFE_BABE);
        idle(1, 0, 0);
        check("flush_idle_busy", 64'(ms_load_busy), 64'd0);

        // Back-to-back ALU ops at full throughput.
        for (int i = 0; i < 10; i++) begin
            step(1, 0, MEM_OP_W, 32'h1000 + 32'(i), 5'(i + 1), 1, 32'h1c00_0100 + 32'(4 * i), 1, 0, 0, 0);
            check("b2b_valid", 64'(ms_to_ws_valid), 64'd1);
            check("b2b_result", 64'(ms_final_result), 64'h1000 + 64'(i));
        end
        idle(1, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            ev   = ($urandom_range(0, 1) == 1);
            ld   = ($urandom_range(0, 2) == 0);
            op   = ld ? 3'($urandom_range(0, 4)) : MEM_OP_W;
            wsal = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 9) == 0);
            dok  = (mem_q.size() != 0) && ($urandom_range(0, 1) == 1);
            if (fl && (mem_q.size() - (dok ? 1 : 0)) > MAX_OUTS) fl = 1'b0;
            step(ev, ld, op, $urandom, 5'($urandom_range(0, 31)), ($urandom_range(0, 1) == 1),
                 $urandom, wsal, fl, dok, $urandom);
        end

        // Asynchronous reset with a load resident.
        step(1, 1, MEM_OP_W, 32'h200, 5'd12, 1, 32'h1c00_0200, 1, 0, 0, 32'h5555_AAAA);
        resetn = 1'b0;
        #1;
        mem_q.delete();
        check("arst_valid", 64'(ms_to_ws_valid), 64'd0);
        check("arst_allowin", 64'(ms_allowin), 64'd1);
        check("arst_load_busy", 64'(ms_load_busy), 64'd0);
        check("arst_fwd_valid", 64'(ms_fwd_valid), 64'd0);
        check("arst_result", 64'(ms_final_result), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
